fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin arbiter sharing the single 8-bit write port of the 64-entry FIFO between N producers.
//   Grants one producer at a time for a burst (up to BURST_MAX beats or until req_last), so bursts land contiguously.
//   Drives the FIFO's wr_en/data_in directly and stalls producers on FIFO full.
//   Releases a stalled grant on timeout so a silent producer cannot starve the others.
// PARAMETERS
//   N          4    number of requesters (2..8)
//   DW         8    data width, matches FIFO data_in
//   BURST_MAX  16   max beats per grant (1..255)
//   IDLE_TO    8    cycles of req_valid low while granted before forced release (1..255)
// PORTS
//   clk           in   1     clock, all logic on rising edge
//   rst           in   1     asynchronous, active-high reset
//   req_valid     in   N     producer i has a beat on req_data[i*DW +: DW]
//   req_data      in   N*DW  producer data, packed, requester 0 in LSBs
//   req_last      in   N     beat on producer i is the last of its burst
//   req_ready     out  N     beat from producer i is accepted this cycle
//   fifo_full     in   1     FIFO full flag
//   fifo_wr_en    out  1     FIFO write enable
//   fifo_wr_data  out  DW    FIFO write data
//   grant         out  N     one-hot current owner, 0 when idle
//   busy          out  1     state == BURST
// BEHAVIOUR
// - Reset (async, any time incl. mid-burst): state=IDLE, grant=0, busy=0, rr_ptr=0, beat_cnt=0, idle_cnt=0.
//   req_ready=0 and fifo_wr_en=0 while rst high; a beat in flight at reset is lost, no FIFO write.
// - States: IDLE, BURST. grant and busy are registered; req_ready, fifo_wr_en, fifo_wr_data are combinational.
// - IDLE: if |req_valid, choose first i with req_valid[i] searching rr_ptr, rr_ptr+1, .. mod N;
//   next cycle grant=onehot(i), state=BURST, beat_cnt=0, idle_cnt=0. Arbitration latency 1 cycle;
//   no beat accepted in IDLE. No request -> stay IDLE, grant=0.
// - BURST (owner g): req_ready[g] = req_valid[g] & ~fifo_full; all other req_ready bits 0.
//   fifo_wr_en = req_ready[g]; fifo_wr_data = req_data[g]. Transfer = fifo_wr_en.
//   Per transfer beat_cnt++ (8-bit, no wrap possible since BURST_MAX<=255), idle_cnt=0.
//   req_valid[g] low: idle_cnt++ (saturating). req_valid[g] high but fifo_full: idle_cnt held (stall != idle).
// - Release (-> IDLE, grant=0 next cycle, rr_ptr=(g+1) mod N) on first of:
//   transfer with req_last[g]=1; transfer making beat_cnt==BURST_MAX; idle_cnt reaching IDLE_TO.
//   req_last on a non-transfer cycle is ignored.
// - Released owner gets lowest priority next arbitration; a producer wins within N arbitrations.
// - Minimum gap between bursts: 1 idle cycle (IDLE state), even if the same producer re-requests.
// - fifo_full held indefinitely: owner stalls, grant held, no timeout (timeout counts only valid-low cycles).
// - Never two bits of grant or req_ready set; fifo_wr_en never high while fifo_full high.
// TESTING
// - Reset: rst=1 with all req_valid=1 -> grant=0, fifo_wr_en=0, req_ready=0; release rst -> grant=4'b0001 after 1 clk.
// - Round-robin: req_valid=4'b1111, each burst 2 beats with last on beat 2 -> grant order 0,1,2,3,0; FIFO gets 8 beats in order.
// - BURST_MAX: producer 1 streams 20 beats, never last -> 16 written, 1 idle cycle, then re-grant to 1 (sole requester), 4 more.
// - Full stall: fifo_full=1 for 30 cycles mid-burst -> req_ready=0, fifo_wr_en=0, grant held, burst resumes without loss.
// - Timeout: owner 2 drops valid after 3 beats -> release exactly IDLE_TO=8 cycles later; waiting producer 3 granted next.
// - Async reset mid-burst (beat 5 of 10): outputs zero immediately; after release, rr_ptr=0, arbitration restarts at requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port between N producers.
// Each grant covers one contiguous burst. A grant is released on req_last, at BURST_MAX beats, or after IDLE_TO idle cycles.
module fifo_wr_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int BURST_MAX = 16,
  parameter int IDLE_TO   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  input  logic [N-1:0]    req_last,
  output logic [N-1:0]    req_ready,
  input  logic            fifo_full,
  output logic            fifo_wr_en,
  output logic [DW-1:0]   fifo_wr_data,
  output logic [N-1:0]    grant,
  output logic            busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t         r_state;
  logic [N-1:0]   r_grant;
  logic [PW-1:0]  r_owner;
  logic [PW-1:0]  r_rr_ptr;
  logic [7:0]     r_beat_cnt;
  logic [7:0]     r_idle_cnt;
  logic           r_busy;

  logic           w_own_valid;
  logic           w_own_last;
  logic           w_xfer;
  logic [DW-1:0]  w_own_data;
  logic           w_any;
  logic [PW-1:0]  w_pick;
  logic [N-1:0]   w_pick_oh;
  logic [PW-1:0]  w_next_ptr;
  logic [7:0]     w_beat_nxt;
  logic [7:0]     w_idle_nxt;
  logic           w_rel_xfer;
  logic           w_rel_idle;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Owner view: everything is masked by the one-hot grant, so idle cycles see zeros.
  always_comb begin
    w_own_data = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant[i]) w_own_data = req_data[i*DW +: DW];
    end
  end

  assign w_own_valid  = |(req_valid & r_grant);
  assign w_own_last   = |(req_last & r_grant);
  assign w_xfer       = (r_state == S_BURST) & w_own_valid & ~fifo_full & ~rst;
  assign req_ready    = w_xfer ? r_grant : '0;
  assign fifo_wr_en   = w_xfer;
  assign fifo_wr_data = w_xfer ? w_own_data : '0;

  // Round-robin search starting at r_rr_ptr; descending k leaves the nearest hit.
  always_comb begin
    int            idx;
    logic [PW-1:0] cand;
    idx    = 0;
    cand   = '0;
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx  = (int'(r_rr_ptr) + k) % N;
      cand = PW'(idx);
      if (req_valid[cand]) begin
        w_any  = 1'b1;
        w_pick = cand;
      end
    end
  end

  assign w_pick_oh  = N'(1) << w_pick;
  assign w_next_ptr = (r_owner == PW'(N-1)) ? '0 : r_owner + 1'b1;
  assign w_beat_nxt = r_beat_cnt + 8'd1;
  assign w_idle_nxt = sat_inc8(r_idle_cnt);

  // A stalled owner (valid high, FIFO full) never counts toward the timeout.
  assign w_rel_xfer = w_xfer & (w_own_last | (w_beat_nxt == 8'(BURST_MAX)));
  assign w_rel_idle = (r_state == S_BURST) & ~w_own_valid & (w_idle_nxt >= 8'(IDLE_TO));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_idle_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state    <= S_BURST;
            r_grant    <= w_pick_oh;
            r_owner    <= w_pick;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
            r_busy     <= 1'b1;
          end
        end
        S_BURST: begin
          if (w_rel_xfer || w_rel_idle) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_rr_ptr   <= w_next_ptr;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
          end else if (w_xfer) begin
            r_beat_cnt <= w_beat_nxt;
            r_idle_cnt <= '0;
          end else if (!w_own_valid) begin
            r_idle_cnt <= w_idle_nxt;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign busy  = r_busy;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic.
// A cycle-level reference model of owner, pointer and counters supplies every expected value.
module tb_fifo_wr_arbiter;
  localparam int N         = 4;
  localparam int DW        = 8;
  localparam int BURST_MAX = 16;
  localparam int IDLE_TO   = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic [N-1:0]    grant;
  logic            busy;

  fifo_wr_arbiter #(.N(N), .DW(DW), .BURST_MAX(BURST_MAX), .IDLE_TO(IDLE_TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: owner index (-1 when idle), priority pointer, counters.
  int m_owner, m_ptr, m_beats, m_idle;
  int seq[N];
  int bcnt[N];
  int burst_len;
  int t_wr;
  logic [N-1:0] s_grant, prev_grant;
  int order_q[$];
  int wcnt_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic m_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_beats = 0;
    m_idle  = 0;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic f);
    req_valid = v;
    fifo_full = f;
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW] = DW'(i*64 + seq[i] % 64);
      if (burst_len > 0)       req_last[i] = (((bcnt[i] + 1) % burst_len) == 0);
      else if (burst_len == 0) req_last[i] = 1'b0;
      else                     req_last[i] = ($urandom % 3) == 0;
    end
  endtask

  task automatic step();
    logic [N-1:0]  eg, er;
    logic          ew, rel, found;
    logic [DW-1:0] ed;
    int            i;
    if (rst) m_reset();
    eg = '0; er = '0; ew = 1'b0; ed = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      if (req_valid[m_owner] && !fifo_full) begin
        er[m_owner] = 1'b1;
        ew = 1'b1;
        ed = req_data[m_owner*DW +: DW];
      end
    end
    #1;
    chk("grant", 32'(grant), 32'(eg));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("wr_en", 32'(fifo_wr_en), 32'(ew));
    if (ew) chk("wr_data", 32'(fifo_wr_data), 32'(ed));
    s_grant = grant;
    if (grant != '0 && prev_grant == '0) begin
      order_q.push_back(oh2i(grant));
      wcnt_q.push_back(0);
    end
    if (fifo_wr_en === 1'b1) begin
      t_wr++;
      if (wcnt_q.size() > 0) wcnt_q[wcnt_q.size()-1]++;
    end
    prev_grant = grant;
    @(posedge clk);
    if (!rst) begin
      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          i = (m_ptr + k) % N;
          if (!found && req_valid[i]) begin
            found = 1'b1;
            m_owner = i;
            m_beats = 0;
            m_idle  = 0;
          end
        end
      end else begin
        rel = 1'b0;
        if (ew) begin
          seq[m_owner]++;
          bcnt[m_owner]++;
          m_beats++;
          m_idle = 0;
          if (req_last[m_owner] || m_beats == BURST_MAX) rel = 1'b1;
        end else if (!req_valid[m_owner]) begin
          m_idle++;
          if (m_idle >= IDLE_TO) rel = 1'b1;
        end
        if (rel) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic cyc(input logic [N-1:0] v, input logic f);
    drive(v, f);
    step();
  endtask

  task automatic rst_phase();
    rst = 1'b1;
    cyc('1, 1'b0);
    cyc('1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) bcnt[i] = 0;
    order_q.delete();
    wcnt_q.delete();
  endtask

  task automatic pad_q();
    while (order_q.size() < 8) begin
      order_q.push_back(-1);
      wcnt_q.push_back(-1);
    end
  endtask

  initial begin
    int st, hold, sum;
    logic done;
    m_reset();
    for (int i = 0; i < N; i++) begin seq[i] = 0; bcnt[i] = 0; end
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
    prev_grant = '0; s_grant = '0; t_wr = 0; burst_len = 2;
    @(negedge clk);

    // Reset with all requesters active, then round-robin over 2-beat bursts.
    cyc('1, 1'b0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    cyc('1, 1'b0);
    rst = 1'b0;
    order_q.delete(); wcnt_q.delete();
    cyc('1, 1'b0);
    cyc('1, 1'b0);
    chk("rst_release", 32'(s_grant), 32'd1);
    for (int k = 0; k < 14; k++) cyc('1, 1'b0);
    pad_q();
    chk("rr0", order_q[0], 0);
    chk("rr1", order_q[1], 1);
    chk("rr2", order_q[2], 2);
    chk("rr3", order_q[3], 3);
    chk("rr4", order_q[4], 0);
    sum = wcnt_q[0] + wcnt_q[1] + wcnt_q[2] + wcnt_q[3];
    chk("rr_beats", sum, 8);

    // BURST_MAX split: producer 1 streams 20 beats without last.
    rst_phase();
    burst_len = 0;
    for (int k = 0; k < 60; k++) cyc((bcnt[1] < 20) ? 4'b0010 : 4'b0000, 1'b0);
    pad_q();
    chk("bmax_owner0", order_q[0], 1);
    chk("bmax_owner1", order_q[1], 1);
    chk("bmax_first", wcnt_q[0], BURST_MAX);
    chk("bmax_second", wcnt_q[1], 4);
    chk("bmax_grants", order_q[2], -1);

    // FIFO full for 30 cycles in the middle of a burst.
    rst_phase();
    for (int k = 0; k < 20 && bcnt[0] < 3; k++) cyc(4'b0001, 1'b0);
    st = t_wr;
    for (int k = 0; k < 30; k++) cyc(4'b0001, 1'b1);
    chk("stall_wr", t_wr - st, 0);
    chk("stall_grant", 32'(s_grant), 32'd1);
    for (int k = 0; k < 10; k++) cyc(4'b0001, 1'b0);
    chk("resume_wr", t_wr - st, 10);

    // Timeout: owner 2 goes silent after 3 beats while producer 3 waits.
    rst_phase();
    for (int k = 0; k < 20 && bcnt[2] < 3; k++) cyc(4'b0100, 1'b0);
    chk("to_beats", bcnt[2], 3);
    hold = 0;
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      cyc(4'b1000, 1'b0);
      if (s_grant == 4'b0100) hold++;
      else done = 1'b1;
    end
    chk("to_hold", hold, IDLE_TO);
    cyc(4'b1000, 1'b0);
    chk("to_next", 32'(s_grant), 32'h8);

    // Async reset while beat 5 is on the bus; pointer must restart at 0.
    rst_phase();
    burst_len = 10;
    for (int k = 0; k < 20 && bcnt[2] < 4; k++) cyc(4'b0100, 1'b0);
    req_valid = 4'b0100;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    cyc(4'b0100, 1'b0);
    rst = 1'b0;
    cyc('1, 1'b0);
    cyc('1, 1'b0);
    chk("arst_rr", 32'(s_grant), 32'd1);

    // Random traffic with occasional resets.
    burst_len = -1;
    for (int k = 0; k < 3000; k++) begin
      rst = (($urandom % 400) == 0);
      cyc(N'($urandom), (($urandom % 4) == 0));
    end
    rst = 1'b0;
    cyc('0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
